key_param_ctrl: RTL and testbench

Key-driven parameter controller sitting between the debounced key block and the measurement datapath's configuration port. It turns one-cycle key pulses and held-key levels into edits of a small register file of NUM_PARAM fields. Editing supports select, increment and decrement with wrap-around, plus long-press auto-repeat. A commit key streams every field to the datapath over a valid/ready write handshake.

---
 rtl/key_param_ctrl_if.sv | 28 ++
 rtl/key_param_ctrl.sv | 162 ++++++++++++++++
 tb/tb_key_param_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/key_param_ctrl_if.sv
// Configuration write port: valid/ready stream of (addr, data)
// pairs plus an end-of-stream done pulse.
interface key_param_ctrl_if #(
  parameter int AW = 2,
  parameter int DW = 8
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          cfg_done;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_data,
    output cfg_done,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_data,
    input  cfg_done,
    output cfg_ready
  );
endinterface

// File: rtl/key_param_ctrl.sv
// Key-driven parameter editor: select/inc/dec with auto-repeat,
// and a commit key that streams every field to the datapath.
module key_param_ctrl #(
  parameter int NUM_PARAM = 4,
  parameter int DW        = 8,
  parameter int MAX_VAL   = 99,
  parameter int HOLD_MS   = 500,
  parameter int REPEAT_MS = 100,
  parameter int AW        = $clog2(NUM_PARAM)
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          tick_1ms,
  input  logic [3:0]    key_pos,
  input  logic [3:0]    key_lvl,
  output logic [AW-1:0] cur_sel,
  output logic [DW-1:0] cur_val,
  output logic          dirty,
  output logic          busy,
  key_param_ctrl_if.master cfg
);

  localparam int CMAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [AW-1:0] LAST     = AW'(NUM_PARAM - 1);
  localparam logic [DW-1:0] MAXV     = DW'(MAX_VAL);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_MS - 1);
  localparam logic [CW-1:0] RPT_END  = CW'(REPEAT_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RPT,
    S_SEND
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [AW-1:0] sel_q, sel_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          dirty_q, dirty_d;
  logic          done_q, done_d;
  logic [DW-1:0] fld_q [NUM_PARAM];

  logic          step;
  logic          step_dir;
  logic [DW-1:0] cur;
  logic [DW-1:0] step_val;
  logic [3:0]    kp1;
  logic          held;

  // isolate the lowest set key bit so it alone is decoded
  assign kp1  = key_pos & (~key_pos + 4'd1);
  assign held = dir_q ? key_lvl[2] : key_lvl[1];
  assign cur  = fld_q[sel_q];

  always_comb begin
    if (step_dir)
      step_val = (cur == '0) ? MAXV : cur - DW'(1);
    else
      step_val = (cur >= MAXV) ? '0 : cur + DW'(1);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    dirty_d  = dirty_q;
    done_d   = 1'b0;
    step     = 1'b0;
    step_dir = dir_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          kp1[0]: sel_d = (sel_q == LAST) ? '0 : sel_q + AW'(1);
          kp1[1], kp1[2]: begin
            step     = 1'b1;
            step_dir = kp1[2];
            dir_d    = kp1[2];
            cnt_d    = '0;
            state_d  = S_HOLD;
          end
          kp1[3]: begin
            idx_d   = '0;
            state_d = S_SEND;
          end
          default: ;
        endcase
      end
      S_HOLD, S_RPT: begin
        if (!held) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (tick_1ms) begin
          if (cnt_q == ((state_q == S_HOLD) ? HOLD_END : RPT_END)) begin
            step    = 1'b1;
            cnt_d   = '0;
            state_d = S_RPT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_SEND: begin
        if (cfg.cfg_ready) begin
          if (idx_q == LAST) begin
            idx_d   = '0;
            done_d  = 1'b1;
            dirty_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (step) dirty_d = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      sel_q   <= '0;
      idx_q   <= '0;
      dirty_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      dirty_q <= dirty_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_PARAM; i++) fld_q[i] <= '0;
    end else if (step) begin
      fld_q[sel_q] <= step_val;
    end
  end

  assign cur_sel       = sel_q;
  assign cur_val       = cur;
  assign dirty         = dirty_q;
  assign busy          = (state_q == S_SEND);
  assign cfg.cfg_valid = busy;
  assign cfg.cfg_addr  = busy ? idx_q : '0;
  assign cfg.cfg_data  = busy ? fld_q[idx_q] : '0;
  assign cfg.cfg_done  = done_q;

endmodule

// File: tb/tb_key_param_ctrl.sv
// Directed bench for key_param_ctrl: edit table, auto-repeat,
// commit stream with stalls, and reset mid-stream.
module tb_key_param_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] key_pos = '0;
  logic [3:0] key_lvl = '0;
  logic [1:0] cur_sel;
  logic [7:0] cur_val;
  logic       dirty;
  logic       busy;

  int errors = 0;
  int checks = 0;

  key_param_ctrl_if #(.AW(2), .DW(8)) cfg ();

  key_param_ctrl dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .tick_1ms  (tick),
    .key_pos   (key_pos),
    .key_lvl   (key_lvl),
    .cur_sel   (cur_sel),
    .cur_val   (cur_val),
    .dirty     (dirty),
    .busy      (busy),
    .cfg       (cfg.master)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [3:0] kp;
    int         sel;
    int         val;
    int         drt;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    key_pos = '0;
    key_lvl = '0;
    tick = 1'b0;
    cfg.cfg_ready = 1'b0;
    rst_n = 1'b0;
    #25;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic press(input logic [3:0] k);
    key_pos = k;
    cyc();
    key_pos = '0;
    cyc();
    cyc();
  endtask

  task automatic commit(input int st_addr, input int st_n,
                        input bit poke, input int e0, input int e1,
                        input int e2, input int e3);
    int ex [4];
    int nw = 0;
    int nd = 0;
    int stl = 0;
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    key_pos = 4'b1000;
    cyc();
    key_pos = '0;
    for (int c = 0; c < 30; c++) begin
      if (cfg.cfg_done) nd++;
      if (cfg.cfg_valid) begin
        if (int'(cfg.cfg_addr) == st_addr && stl < st_n) begin
          chk("stall_data", cfg.cfg_data, ex[st_addr]);
          cfg.cfg_ready = 1'b0;
          stl++;
          if (poke) key_pos = 4'b0010;
        end else begin
          cfg.cfg_ready = 1'b1;
          chk("wr_addr", cfg.cfg_addr, nw);
          if (nw < 4) chk("wr_data", cfg.cfg_data, ex[nw]);
          nw++;
        end
      end else begin
        cfg.cfg_ready = 1'b0;
      end
      cyc();
      key_pos = '0;
    end
    chk("n_writes", nw, 4);
    chk("n_done", nd, 1);
    chk("dirty_after", dirty, 0);
    chk("busy_after", busy, 0);
  endtask

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{4'b0010, 0, 1, 1};
    tbl[1]  = '{4'b0010, 0, 2, 1};
    tbl[2]  = '{4'b0010, 0, 3, 1};
    tbl[3]  = '{4'b0001, 1, 0, 1};
    tbl[4]  = '{4'b0100, 1, 99, 1};
    tbl[5]  = '{4'b0010, 1, 0, 1};
    tbl[6]  = '{4'b0110, 1, 1, 1};
    tbl[7]  = '{4'b0001, 2, 0, 1};
    tbl[8]  = '{4'b0001, 3, 0, 1};
    tbl[9]  = '{4'b0001, 0, 3, 1};
    tbl[10] = '{4'b1001, 1, 1, 1};

    do_reset();
    chk("rst_sel", cur_sel, 0);
    chk("rst_val", cur_val, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", cfg.cfg_valid, 0);
    chk("rst_addr", cfg.cfg_addr, 0);
    chk("rst_data", cfg.cfg_data, 0);
    chk("rst_done", cfg.cfg_done, 0);

    for (int i = 0; i < 11; i++) begin
      key_pos = tbl[i].kp;
      cyc();
      key_pos = '0;
      chk($sformatf("v%0d_sel", i), cur_sel, tbl[i].sel);
      chk($sformatf("v%0d_val", i), cur_val, tbl[i].val);
      chk($sformatf("v%0d_dirty", i), dirty, tbl[i].drt);
      cyc();
      cyc();
    end

    // long press: immediate step, step at 500 ticks, then every 100
    do_reset();
    key_pos = 4'b0010;
    key_lvl = 4'b0010;
    cyc();
    key_pos = '0;
    chk("hold_first", cur_val, 1);
    for (int t = 1; t <= 1000; t++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
      if (t == 499) chk("hold_499", cur_val, 1);
      if (t == 500) chk("hold_500", cur_val, 2);
      if (t == 599) chk("rpt_599", cur_val, 2);
      if (t == 600) chk("rpt_600", cur_val, 3);
    end
    chk("rpt_1000", cur_val, 7);
    key_lvl = '0;
    cyc();
    cyc();
    for (int t = 0; t < 150; t++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
    chk("release_val", cur_val, 7);
    chk("release_dirty", dirty, 1);
    press(4'b0001);
    chk("release_sel", cur_sel, 1);

    // load {5,10,15,20} then commit
    do_reset();
    for (int f = 0; f < 4; f++) begin
      repeat ((f + 1) * 5) press(4'b0010);
      press(4'b0001);
    end
    chk("load_sel", cur_sel, 0);
    chk("load_val", cur_val, 5);
    chk("load_dirty", dirty, 1);
    commit(-1, 0, 1'b0, 5, 10, 15, 20);

    // clean commit, stall on addr 2, inc poked mid-stream
    commit(2, 3, 1'b1, 5, 10, 15, 20);
    chk("poke_val", cur_val, 5);
    chk("poke_dirty", dirty, 0);

    // reset with addr 2 outstanding
    key_pos = 4'b1000;
    cyc();
    key_pos = '0;
    cfg.cfg_ready = 1'b1;
    cyc();
    cyc();
    chk("mid_addr", cfg.cfg_addr, 2);
    cfg.cfg_ready = 1'b0;
    #5;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", cfg.cfg_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", cfg.cfg_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cfg.cfg_ready = 1'b1;
    begin
      int nd = 0;
      int nv = 0;
      for (int c = 0; c < 8; c++) begin
        cyc();
        if (cfg.cfg_done) nd++;
        if (cfg.cfg_valid) nv++;
      end
      chk("arst_no_done", nd, 0);
      chk("arst_no_valid", nv, 0);
    end
    chk("arst_sel", cur_sel, 0);
    chk("arst_val0", cur_val, 0);
    chk("arst_dirty", dirty, 0);
    press(4'b0001);
    chk("arst_val1", cur_val, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
